memory_dumper: RTL

MEMORY_DUMPER -- requirements
Module: memory_dumper

---
 rtl/memory_dumper.sv | 129 ++++++++++++
 1 files changed

// File: rtl/memory_dumper.sv
// memory_dumper: streams instruction memory, then data memory minus the memory-mapped
// I/O hole, over a valid/ready port. Optional trailing checksum word: `DUMP_CHECKSUM_EN.
module memory_dumper #(
  parameter int MEMMAPSTARTADDR = 384,
  parameter int MEMMAPENDADDR   = 511
) (
  input  logic        clk,
  input  logic        sync_rst,
  input  logic        clk_en,
  input  logic        DumpInit,
  output logic        InstReadEn,
  output logic        DataReadEn,
  output logic [9:0]  ReadAddr,
  input  logic [15:0] ReadData,
  output logic        StreamValid,
  input  logic        StreamReady,
  output logic [15:0] StreamData,
  output logic        DumpBusy,
  output logic        DumpDone
);

  // Counter bit 9 selects data space, so hole words sit at 512 + word index.
  localparam logic [10:0] HoleFirst  = 11'(512 + MEMMAPSTARTADDR / 2);
  localparam logic [10:0] HoleResume = 11'(512 + (MEMMAPENDADDR - 1) / 2 + 1);

`ifdef DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, READ, CAPTURE, SEND, CSUM, DONE} stateT;
`else
  typedef enum logic [2:0] {IDLE, READ, CAPTURE, SEND, DONE} stateT;
`endif

  stateT       stateReg, stateNext;
  logic [10:0] wordCntReg, wordCntNext;
  logic [10:0] wordInc;
  logic [15:0] streamDataReg, streamDataNext;
`ifdef DUMP_CHECKSUM_EN
  logic [15:0] checksumReg, checksumNext;
`endif

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      stateReg      <= IDLE;
      wordCntReg    <= '0;
      streamDataReg <= '0;
`ifdef DUMP_CHECKSUM_EN
      checksumReg   <= '0;
`endif
    end else if (clk_en) begin
      stateReg      <= stateNext;
      wordCntReg    <= wordCntNext;
      streamDataReg <= streamDataNext;
`ifdef DUMP_CHECKSUM_EN
      checksumReg   <= checksumNext;
`endif
    end
  end

  always_comb begin
    stateNext      = stateReg;
    wordCntNext    = wordCntReg;
    streamDataNext = streamDataReg;
`ifdef DUMP_CHECKSUM_EN
    checksumNext   = checksumReg;
`endif
    InstReadEn  = 1'b0;
    DataReadEn  = 1'b0;
    StreamValid = 1'b0;
    DumpBusy    = 1'b1;
    DumpDone    = 1'b0;
    wordInc     = wordCntReg + 11'd1;

    case (stateReg)
      IDLE, DONE: begin
        DumpBusy = 1'b0;
        DumpDone = (stateReg == DONE);
        if (DumpInit) begin
          stateNext   = READ;
          wordCntNext = '0;
`ifdef DUMP_CHECKSUM_EN
          checksumNext = '0;
`endif
        end
      end

      READ: begin
        InstReadEn = ~wordCntReg[9];
        DataReadEn = wordCntReg[9];
        stateNext  = CAPTURE;
      end

      CAPTURE: begin
        streamDataNext = ReadData;
        stateNext      = SEND;
      end

      SEND: begin
        StreamValid = 1'b1;
        if (StreamReady) begin
          // Jump straight over the I/O hole instead of reading it.
          wordCntNext = (wordInc == HoleFirst) ? HoleResume : wordInc;
`ifdef DUMP_CHECKSUM_EN
          checksumNext = checksumReg + streamDataReg;
          if (wordCntNext[10]) begin
            stateNext      = CSUM;
            streamDataNext = checksumNext;
          end else begin
            stateNext = READ;
          end
`else
          stateNext = wordCntNext[10] ? DONE : READ;
`endif
        end
      end

`ifdef DUMP_CHECKSUM_EN
      CSUM: begin
        StreamValid = 1'b1;
        if (StreamReady) stateNext = DONE;
      end
`endif

      default: stateNext = IDLE;
    endcase
  end

  assign ReadAddr   = {wordCntReg[8:0], 1'b0};
  assign StreamData = streamDataReg;

endmodule
